// File: rtl/conv_pkg.sv
// Shared window geometry and pixel/window types for the 3x3 convolution front end.
package conv_pkg;
    localparam int WIN_K = 3;
    localparam int WIN_N = WIN_K * WIN_K;
    localparam int PIX_W = 8;

    typedef logic [PIX_W-1:0] pix_t;
    typedef pix_t [WIN_N-1:0] win_t;
endpackage

// File: rtl/linebuf_ram.sv
// One line of pixel storage: single write port, asynchronous read at the same
// address, so a read in the write cycle returns the old (read-before-write) word.
module linebuf_ram #(
    parameter int pDATA_W = 8,
    parameter int pDEPTH  = 32,
    parameter int pADDR_W = (pDEPTH > 1) ? $clog2(pDEPTH) : 1
) (
    input  logic               clk,
    input  logic               we,
    input  logic [pADDR_W-1:0] addr,
    input  logic [pDATA_W-1:0] wdata,
    output logic [pDATA_W-1:0] rdata
);
    logic [pDATA_W-1:0] mem [pDEPTH];

    assign rdata = mem[addr];

    // Contents are deliberately not reset; rows 0/1 of each frame overwrite them.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end
endmodule

// File: rtl/window3x3_gen.sv
// Raster pixel stream to 3x3 neighbourhood generator: two line buffers feed the
// right-hand column of a 3x3 shift window; only windows fully inside the image are flagged.
module window3x3_gen
    import conv_pkg::*;
#(
    parameter int pDATA_W = 8,
    parameter int pIMG_W  = 32,
    parameter int pIMG_H  = 32
) (
    input  logic                              iclk,
    input  logic                              irst_n,
    input  logic                              ivalid,
    input  logic                              isof,
    input  logic [pDATA_W-1:0]                idata,
    output logic [WIN_N-1:0][pDATA_W-1:0]     owin,
    output logic                              ovalid,
    output logic                              oframe_done
);
    localparam int CW = $clog2(pIMG_W);
    localparam int RW = $clog2(pIMG_H);
    localparam logic [CW-1:0] COL_LAST = CW'(pIMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(pIMG_H - 1);
    localparam logic [CW-1:0] COL_MIN  = CW'(WIN_K - 1);
    localparam logic [RW-1:0] ROW_MIN  = RW'(WIN_K - 1);

    logic [CW-1:0]      col;
    logic [RW-1:0]      row;
    logic [CW-1:0]      cur_col;
    logic [RW-1:0]      cur_row;
    logic [pDATA_W-1:0] lb0_q;
    logic [pDATA_W-1:0] lb1_q;

    // A start-of-frame pixel is position (0,0) whatever the counters say.
    assign cur_col = isof ? '0 : col;
    assign cur_row = isof ? '0 : row;

    linebuf_ram #(.pDATA_W(pDATA_W), .pDEPTH(pIMG_W), .pADDR_W(CW)) u_lb0 (
        .clk   (iclk),
        .we    (ivalid),
        .addr  (cur_col),
        .wdata (idata),
        .rdata (lb0_q)
    );

    linebuf_ram #(.pDATA_W(pDATA_W), .pDEPTH(pIMG_W), .pADDR_W(CW)) u_lb1 (
        .clk   (iclk),
        .we    (ivalid),
        .addr  (cur_col),
        .wdata (lb0_q),
        .rdata (lb1_q)
    );

    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            col         <= '0;
            row         <= '0;
            owin        <= '0;
            ovalid      <= 1'b0;
            oframe_done <= 1'b0;
        end else begin
            ovalid      <= 1'b0;
            oframe_done <= 1'b0;
            if (ivalid) begin
                for (int r = 0; r < WIN_K; r++) begin
                    owin[r*WIN_K]     <= owin[r*WIN_K + 1];
                    owin[r*WIN_K + 1] <= owin[r*WIN_K + 2];
                end
                owin[2] <= lb1_q;
                owin[5] <= lb0_q;
                owin[8] <= idata;

                ovalid      <= (cur_row >= ROW_MIN) && (cur_col >= COL_MIN);
                oframe_done <= (cur_row == ROW_LAST) && (cur_col == COL_LAST);

                if (cur_col == COL_LAST) begin
                    col <= '0;
                    row <= (cur_row == ROW_LAST) ? '0 : cur_row + 1'b1;
                end else begin
                    col <= cur_col + 1'b1;
                    row <= cur_row;
                end
            end
        end
    end
endmodule

// File: tb/tb_window3x3_gen.sv
// Directed bench for window3x3_gen: a 4x4 instance for hand-checked frames and a
// 32x32 instance fed random data against a full-frame reference extraction.
module tb_window3x3_gen;
    import conv_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // 4x4 instance
    logic       v4 = 1'b0, s4 = 1'b0;
    logic [7:0] d4 = '0;
    win_t       w4;
    logic       ov4, fd4;

    // 32x32 instance
    logic       v32 = 1'b0, s32 = 1'b0;
    logic [7:0] d32 = '0;
    win_t       w32;
    logic       ov32, fd32;

    window3x3_gen #(.pDATA_W(8), .pIMG_W(4), .pIMG_H(4)) u4 (
        .iclk(clk), .irst_n(rst_n), .ivalid(v4), .isof(s4), .idata(d4),
        .owin(w4), .ovalid(ov4), .oframe_done(fd4)
    );

    window3x3_gen #(.pDATA_W(8), .pIMG_W(32), .pIMG_H(32)) u32 (
        .iclk(clk), .irst_n(rst_n), .ivalid(v32), .isof(s32), .idata(d32),
        .owin(w32), .ovalid(ov32), .oframe_done(fd32)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Hand formula for a 4x4 window whose top-left pixel is b (pixel = b + r*4 + c).
    function automatic win_t win4(input int b);
        win_t w;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                w[r*3+c] = 8'(b + r*4 + c);
        return w;
    endfunction

    // Reference model state: full-frame image plus raster position.
    logic [7:0] img4 [4][4];
    int         mr4 = 0, mc4 = 0;
    logic       ev4 = 1'b0, ed4 = 1'b0;
    logic [71:0] exp_q4[$];
    win_t       got_q4[$];
    int         done_cnt4 = 0;

    logic [7:0] img32 [32][32];
    int         mr32 = 0, mc32 = 0;
    logic       ev32 = 1'b0, ed32 = 1'b0;
    logic [71:0] exp_q32[$];
    int         win_cnt32 = 0, done_cnt32 = 0;

    task automatic send4(input logic [7:0] d, input logic sof);
        win_t w;
        @(posedge clk); #1;
        v4 = 1'b1; s4 = sof; d4 = d;
        if (sof) begin mr4 = 0; mc4 = 0; end
        img4[mr4][mc4] = d;
        ev4 = (mr4 >= 2) && (mc4 >= 2);
        ed4 = (mr4 == 3) && (mc4 == 3);
        if (ev4) begin
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++)
                    w[r*3+c] = img4[mr4-2+r][mc4-2+c];
            exp_q4.push_back(w);
        end
        mc4++;
        if (mc4 == 4) begin mc4 = 0; mr4++; if (mr4 == 4) mr4 = 0; end
    endtask

    task automatic idle4();
        @(posedge clk); #1;
        v4 = 1'b0; s4 = 1'b0; ev4 = 1'b0; ed4 = 1'b0;
    endtask

    task automatic frame4(input int base, input logic sof, input logic gap);
        for (int i = 0; i < 16; i++) begin
            send4(8'(base + i), sof && (i == 0));
            if (gap) idle4();
        end
    endtask

    task automatic send32(input logic [7:0] d);
        win_t w;
        @(posedge clk); #1;
        v32 = 1'b1; s32 = 1'b0; d32 = d;
        img32[mr32][mc32] = d;
        ev32 = (mr32 >= 2) && (mc32 >= 2);
        ed32 = (mr32 == 31) && (mc32 == 31);
        if (ev32) begin
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++)
                    w[r*3+c] = img32[mr32-2+r][mc32-2+c];
            exp_q32.push_back(w);
        end
        mc32++;
        if (mc32 == 32) begin mc32 = 0; mr32++; if (mr32 == 32) mr32 = 0; end
    endtask

    // Scoreboards: sample the flags the driver set for this edge, check #2 later.
    logic cv4, ce4, cd4;
    always @(posedge clk) begin
        cv4 = v4; ce4 = ev4; cd4 = ed4;
        #2;
        if (rst_n) begin
            check("ovalid4", ov4, ce4 & cv4);
            check("frame_done4", fd4, cd4 & cv4);
            if (ov4) begin
                got_q4.push_back(w4);
                if (exp_q4.size() > 0) check("owin4", w4, exp_q4.pop_front());
                else check("owin4_unexpected", ov4, 1'b0);
            end
            if (fd4) done_cnt4++;
        end
    end

    logic cv32, ce32, cd32;
    always @(posedge clk) begin
        cv32 = v32; ce32 = ev32; cd32 = ed32;
        #2;
        if (rst_n) begin
            check("ovalid32", ov32, ce32 & cv32);
            check("frame_done32", fd32, cd32 & cv32);
            if (ov32) begin
                win_cnt32++;
                if (exp_q32.size() > 0) check("owin32", w32, exp_q32.pop_front());
                else check("owin32_unexpected", ov32, 1'b0);
            end
            if (fd32) done_cnt32++;
        end
    end

    task automatic start_test();
        got_q4.delete();
        done_cnt4 = 0;
    endtask

    task automatic end_test4(input string tag, input int n_win);
        repeat (3) idle4();
        check({tag, "_win_count"}, got_q4.size(), n_win);
        check({tag, "_done_count"}, done_cnt4, 1);
        check({tag, "_queue_empty"}, exp_q4.size(), 0);
    endtask

    initial begin
        #2;
        check("rst_owin4", w4, '0);
        check("rst_ovalid4", ov4, 1'b0);
        check("rst_done4", fd4, 1'b0);
        check("rst_owin32", w32, '0);
        check("rst_ovalid32", ov32, 1'b0);
        check("rst_done32", fd32, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Continuous 4x4 frame
        start_test();
        frame4(0, 1'b0, 1'b0);
        end_test4("cont", 4);
        check("cont_first", got_q4[0], win4(0));
        check("cont_last", got_q4[3], win4(5));

        // Same frame with ivalid toggling
        start_test();
        frame4(0, 1'b0, 1'b1);
        end_test4("gap", 4);
        check("gap_w0", got_q4[0], win4(0));
        check("gap_w1", got_q4[1], win4(1));
        check("gap_w2", got_q4[2], win4(4));
        check("gap_w3", got_q4[3], win4(5));

        // Back-to-back frames, no idle between them
        start_test();
        frame4(0, 1'b0, 1'b0);
        frame4(100, 1'b0, 1'b0);
        repeat (3) idle4();
        check("b2b_win_count", got_q4.size(), 8);
        check("b2b_done_count", done_cnt4, 2);
        check("b2b_second_first", got_q4[4], win4(100));
        check("b2b_second_last", got_q4[7], win4(105));

        // Partial frame abandoned by isof
        start_test();
        for (int i = 0; i < 6; i++) send4(8'(i), 1'b0);
        frame4(50, 1'b1, 1'b0);
        end_test4("sof", 4);
        check("sof_first", got_q4[0], win4(50));

        // Reset pulse mid-frame
        start_test();
        for (int i = 0; i < 10; i++) send4(8'(i), 1'b0);
        @(posedge clk); #1;
        v4 = 1'b0; ev4 = 1'b0; ed4 = 1'b0;
        rst_n = 1'b0; mr4 = 0; mc4 = 0;
        #1;
        check("midrst_owin", w4, '0);
        check("midrst_ovalid", ov4, 1'b0);
        check("midrst_done", fd4, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        frame4(0, 1'b0, 1'b0);
        end_test4("postrst", 4);
        check("postrst_first", got_q4[0], win4(0));
        check("postrst_last", got_q4[3], win4(5));

        // 32x32 random frame
        for (int i = 0; i < 1024; i++) send32(8'($urandom_range(0, 255)));
        @(posedge clk); #1;
        v32 = 1'b0; ev32 = 1'b0; ed32 = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        check("big_win_count", win_cnt32, 900);
        check("big_done_count", done_cnt32, 1);
        check("big_queue_empty", exp_q32.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
